// File: rtl/pu_pkg.sv
// Shared definitions for the PU PReLU sequencer: state encoding, the slope
// packing order inside one parameter-buffer word, and word width constants.
package pu_pkg;

  // One parameter word carries the slopes of one 4-OC group.
  localparam int NUM_OC            = 4;
  localparam int DEF_RELU_PARAM_WD = 8;
  localparam int PARAM_WORD_WD     = NUM_OC * DEF_RELU_PARAM_WD;

  // Sequencer state encoding.
  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_RUN   = 3'd3;
  localparam logic [2:0] ST_DONE  = 3'd4;

  // LSB position of slope `oc` inside a parameter word; oc0 sits in the MSBs.
  function automatic int slope_lsb(input int oc, input int slope_wd);
    return (NUM_OC - 1 - oc) * slope_wd;
  endfunction

endpackage

// File: rtl/pu_relu_ctrl.sv
// Sequencer for the 4-OC PReLU multiply stage. Walks OC groups and rows of a
// layer, fetches each group's slopes from the parameter buffer and only lets
// rows through to the pipe while the slopes for that group are stable.
module pu_relu_ctrl
  import pu_pkg::*;
#(
  parameter int RELU_PARAM_WD = PARAM_WORD_WD / NUM_OC,
  parameter int OC_GRP_WD     = 6,
  parameter int OH_WD         = 10,
  parameter int PARAM_AW      = 8
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              start_i,
  input  logic                              cfg_prelu_en_i,
  input  logic [OC_GRP_WD-1:0]              cfg_grp_num_m1_i,
  input  logic [OH_WD-1:0]                  cfg_oh_num_m1_i,
  input  logic [PARAM_AW-1:0]               cfg_param_base_i,
  output logic                              busy_o,
  output logic                              done_o,
  output logic                              prm_rd_en_o,
  output logic [PARAM_AW-1:0]               prm_rd_addr_o,
  input  logic [NUM_OC*RELU_PARAM_WD-1:0]   prm_rd_data_i,
  input  logic                              conv_vld_i,
  output logic                              conv_rdy_o,
  output logic                              pipe_vld_o,
  input  logic                              pipe_rdy_i,
  output logic [RELU_PARAM_WD-1:0]          relu_para_oc0_o,
  output logic [RELU_PARAM_WD-1:0]          relu_para_oc1_o,
  output logic [RELU_PARAM_WD-1:0]          relu_para_oc2_o,
  output logic [RELU_PARAM_WD-1:0]          relu_para_oc3_o,
  output logic [OC_GRP_WD-1:0]              grp_idx_o,
  output logic [OH_WD-1:0]                  row_idx_o
);

  logic [2:0]               r_state;
  logic [2:0]               w_state_next;

  // Layer configuration, frozen at start so cfg_* may change freely later.
  logic                     r_prelu_en;
  logic [OC_GRP_WD-1:0]     r_grp_m1;
  logic [OH_WD-1:0]         r_oh_m1;
  logic [PARAM_AW-1:0]      r_base;

  logic [OC_GRP_WD-1:0]     r_grp;
  logic [OH_WD-1:0]         r_row;
  logic [RELU_PARAM_WD-1:0] r_slope [NUM_OC];
  logic [RELU_PARAM_WD-1:0] w_slope_rd [NUM_OC];

  logic                     w_accept;
  logic                     w_row_last;
  logic                     w_grp_last;

  assign w_accept   = (r_state == ST_RUN) && conv_vld_i && pipe_rdy_i;
  assign w_row_last = (r_row == r_oh_m1);
  assign w_grp_last = (r_grp == r_grp_m1);

  // Unpack the buffer word into per-OC slopes.
  for (genvar gi = 0; gi < NUM_OC; gi++) begin : g_slope
    localparam int LSB = slope_lsb(gi, RELU_PARAM_WD);
    assign w_slope_rd[gi] = prm_rd_data_i[LSB +: RELU_PARAM_WD];
  end

  assign relu_para_oc0_o = r_slope[0];
  assign relu_para_oc1_o = r_slope[1];
  assign relu_para_oc2_o = r_slope[2];
  assign relu_para_oc3_o = r_slope[3];
  assign grp_idx_o       = r_grp;
  assign row_idx_o       = r_row;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; without PReLU a group change goes straight back to RUN.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_next = cfg_prelu_en_i ? ST_FETCH : ST_RUN;
        end
      end
      ST_FETCH: w_state_next = ST_WAIT;
      ST_WAIT:  w_state_next = ST_RUN;
      ST_RUN: begin
        if (w_accept && w_row_last) begin
          if (w_grp_last) begin
            w_state_next = ST_DONE;
          end else begin
            w_state_next = r_prelu_en ? ST_FETCH : ST_RUN;
          end
        end
      end
      ST_DONE:  w_state_next = ST_IDLE;
      default:  w_state_next = ST_IDLE;
    endcase
  end

  // Outputs: handshake passes through only in RUN so slopes never change under a beat.
  always_comb begin
    busy_o        = 1'b0;
    done_o        = 1'b0;
    prm_rd_en_o   = 1'b0;
    prm_rd_addr_o = '0;
    pipe_vld_o    = 1'b0;
    conv_rdy_o    = 1'b0;
    case (r_state)
      ST_FETCH: begin
        busy_o        = 1'b1;
        prm_rd_en_o   = 1'b1;
        prm_rd_addr_o = r_base + PARAM_AW'(r_grp);
      end
      ST_WAIT: begin
        busy_o = 1'b1;
      end
      ST_RUN: begin
        busy_o     = 1'b1;
        pipe_vld_o = conv_vld_i;
        conv_rdy_o = pipe_rdy_i;
      end
      ST_DONE: begin
        done_o = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Config latch, group/row counters and slope registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prelu_en <= 1'b0;
      r_grp_m1   <= '0;
      r_oh_m1    <= '0;
      r_base     <= '0;
      r_grp      <= '0;
      r_row      <= '0;
      for (int k = 0; k < NUM_OC; k++) begin
        r_slope[k] <= '0;
      end
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_i) begin
            r_prelu_en <= cfg_prelu_en_i;
            r_grp_m1   <= cfg_grp_num_m1_i;
            r_oh_m1    <= cfg_oh_num_m1_i;
            r_base     <= cfg_param_base_i;
            r_grp      <= '0;
            r_row      <= '0;
            // Plain ReLU: slopes are zero for the whole layer.
            if (!cfg_prelu_en_i) begin
              for (int k = 0; k < NUM_OC; k++) begin
                r_slope[k] <= '0;
              end
            end
          end
        end
        ST_WAIT: begin
          for (int k = 0; k < NUM_OC; k++) begin
            r_slope[k] <= w_slope_rd[k];
          end
        end
        ST_RUN: begin
          // Terminal compare comes first so the counters never wrap.
          if (w_accept) begin
            if (w_row_last) begin
              if (!w_grp_last) begin
                r_row <= '0;
                r_grp <= r_grp + OC_GRP_WD'(1);
              end
            end else begin
              r_row <= r_row + OH_WD'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pu_relu_ctrl.sv
// Directed bench for pu_relu_ctrl with a registered-read parameter buffer model.
module tb_pu_relu_ctrl;

  localparam int W  = 8;
  localparam int GW = 6;
  localparam int OW = 10;
  localparam int AW = 8;

  logic            clk = 1'b0;
  logic            rst;
  logic            start_i;
  logic            cfg_prelu_en_i;
  logic [GW-1:0]   cfg_grp_num_m1_i;
  logic [OW-1:0]   cfg_oh_num_m1_i;
  logic [AW-1:0]   cfg_param_base_i;
  logic            busy_o;
  logic            done_o;
  logic            prm_rd_en_o;
  logic [AW-1:0]   prm_rd_addr_o;
  logic [4*W-1:0]  prm_rd_data_i;
  logic            conv_vld_i;
  logic            conv_rdy_o;
  logic            pipe_vld_o;
  logic            pipe_rdy_i;
  logic [W-1:0]    oc0, oc1, oc2, oc3;
  logic [GW-1:0]   grp_idx_o;
  logic [OW-1:0]   row_idx_o;

  logic [4*W-1:0]  mem [256];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic           rd;
    logic [AW-1:0]  addr;
    logic           acc;
    logic           done;
    logic           busy;
    logic           crdy;
    logic           pvld;
    logic           vld;
    logic           rdy;
    logic [GW-1:0]  grp;
    logic [OW-1:0]  row;
    logic [4*W-1:0] slope;
  } cyc_t;

  cyc_t trace[$];

  pu_relu_ctrl dut (
    .clk              (clk),
    .rst              (rst),
    .start_i          (start_i),
    .cfg_prelu_en_i   (cfg_prelu_en_i),
    .cfg_grp_num_m1_i (cfg_grp_num_m1_i),
    .cfg_oh_num_m1_i  (cfg_oh_num_m1_i),
    .cfg_param_base_i (cfg_param_base_i),
    .busy_o           (busy_o),
    .done_o           (done_o),
    .prm_rd_en_o      (prm_rd_en_o),
    .prm_rd_addr_o    (prm_rd_addr_o),
    .prm_rd_data_i    (prm_rd_data_i),
    .conv_vld_i       (conv_vld_i),
    .conv_rdy_o       (conv_rdy_o),
    .pipe_vld_o       (pipe_vld_o),
    .pipe_rdy_i       (pipe_rdy_i),
    .relu_para_oc0_o  (oc0),
    .relu_para_oc1_o  (oc1),
    .relu_para_oc2_o  (oc2),
    .relu_para_oc3_o  (oc3),
    .grp_idx_o        (grp_idx_o),
    .row_idx_o        (row_idx_o)
  );

  always #5 clk = ~clk;

  // Parameter buffer: data valid one cycle after the read strobe.
  always_ff @(posedge clk) begin
    if (prm_rd_en_o) prm_rd_data_i <= mem[prm_rd_addr_o];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a layer with the cfg already on the pins, then records one entry per cycle.
  task automatic run_layer(input int vld_mode, input int rdy_mode, input int max_cycles,
                           input int inject_at, input bit rst_g1r1, input bit start_on_done,
                           output bit timed_out, output bit rst_fired);
    cyc_t r;
    bit fin;
    trace.delete();
    timed_out = 1'b1;
    rst_fired = 1'b0;
    fin = 1'b0;
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < max_cycles && !fin; c++) begin
      conv_vld_i = (vld_mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
      pipe_rdy_i = (rdy_mode == 0) ? 1'b1 : ((c % 2) == 0);
      cfg_prelu_en_i   = 1'($urandom_range(0, 1));
      cfg_grp_num_m1_i = GW'($urandom);
      cfg_oh_num_m1_i  = OW'($urandom);
      cfg_param_base_i = AW'($urandom);
      start_i = (c == inject_at);
      #1;
      r.rd    = prm_rd_en_o;
      r.addr  = prm_rd_addr_o;
      r.vld   = conv_vld_i;
      r.rdy   = pipe_rdy_i;
      r.pvld  = pipe_vld_o;
      r.crdy  = conv_rdy_o;
      r.acc   = pipe_vld_o & pipe_rdy_i;
      r.done  = done_o;
      r.busy  = busy_o;
      r.grp   = grp_idx_o;
      r.row   = row_idx_o;
      r.slope = {oc0, oc1, oc2, oc3};
      trace.push_back(r);
      $display("  cyc %0d rd=%0b addr=%02h vld=%0b rdy=%0b acc=%0b grp=%0d row=%0d slope=%08h busy=%0b done=%0b",
               c, r.rd, r.addr, r.vld, r.rdy, r.acc, r.grp, r.row, r.slope, r.busy, r.done);
      if (rst_g1r1 && r.pvld && r.grp == 1 && r.row == 1) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
        rst_fired = 1'b1;
        timed_out = 1'b0;
        fin = 1'b1;
      end else begin
        if (r.done) begin
          if (start_on_done) begin
            start_i = 1'b1;
            cfg_prelu_en_i = 1'b1;
          end
          fin = 1'b1;
          timed_out = 1'b0;
        end
        tick();
        start_i = 1'b0;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    conv_vld_i = 1'b1;
    pipe_rdy_i = 1'b1;
    tick();
    tick();
    checks++;
    if ({busy_o, done_o, prm_rd_en_o, pipe_vld_o, conv_rdy_o} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl: got %05b expected 00000", {busy_o, done_o, prm_rd_en_o, pipe_vld_o, conv_rdy_o});
    end
    checks++;
    if ({prm_rd_addr_o, oc0, oc1, oc2, oc3, grp_idx_o, row_idx_o} !== '0) begin
      errors++;
      $display("FAIL reset_data: got addr=%0h slopes=%0h grp=%0d row=%0d expected all 0",
               prm_rd_addr_o, {oc0, oc1, oc2, oc3}, grp_idx_o, row_idx_o);
    end
    rst = 1'b0;
    conv_vld_i = 1'b0;
    tick();
    $display("test_reset done");
  endtask

  task automatic test_prelu_layer();
    bit to, rf;
    int n_rd, n_acc, n_done, n_bub;
    logic [4*W-1:0] exp_slope;
    n_rd = 0; n_acc = 0; n_done = 0; n_bub = 0;
    mem[8'h10] = 32'h01020304;
    mem[8'h11] = 32'h05060708;
    cfg_prelu_en_i = 1'b1; cfg_grp_num_m1_i = 1; cfg_oh_num_m1_i = 2; cfg_param_base_i = 8'h10;
    run_layer(0, 0, 50, -1, 1'b0, 1'b0, to, rf);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL prelu_timeout: got no done, expected done"); end
    foreach (trace[i]) begin
      if (trace[i].rd) begin
        checks++;
        if (trace[i].addr !== ((n_rd == 0) ? 8'h10 : 8'h11)) begin
          errors++;
          $display("FAIL prelu_rd_addr: got %02h expected %02h", trace[i].addr, (n_rd == 0) ? 8'h10 : 8'h11);
        end
        n_rd++;
      end
      if (trace[i].acc) begin
        exp_slope = (n_acc < 3) ? 32'h01020304 : 32'h05060708;
        checks++;
        if ({trace[i].grp, trace[i].row, trace[i].slope} !== {GW'(n_acc / 3), OW'(n_acc % 3), exp_slope}) begin
          errors++;
          $display("FAIL prelu_beat%0d: got grp=%0d row=%0d slope=%08h expected grp=%0d row=%0d slope=%08h",
                   n_acc, trace[i].grp, trace[i].row, trace[i].slope, n_acc / 3, n_acc % 3, exp_slope);
        end
        n_acc++;
      end
      if (trace[i].done) n_done++;
      if (trace[i].busy && !trace[i].acc) n_bub++;
    end
    checks++;
    if (n_rd !== 2) begin errors++; $display("FAIL prelu_rd_count: got %0d expected 2", n_rd); end
    checks++;
    if (n_acc !== 6) begin errors++; $display("FAIL prelu_accepts: got %0d expected 6", n_acc); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL prelu_done_count: got %0d expected 1", n_done); end
    checks++;
    if (n_bub !== 4) begin errors++; $display("FAIL prelu_bubbles: got %0d expected 4", n_bub); end
    checks++;
    if (trace.size() !== 11) begin errors++; $display("FAIL prelu_length: got %0d cycles expected 11", trace.size()); end
    checks++;
    if ({trace[trace.size()-1].done, trace[trace.size()-1].busy} !== 2'b10) begin
      errors++;
      $display("FAIL prelu_done_busy: got done,busy=%0b%0b expected 10",
               trace[trace.size()-1].done, trace[trace.size()-1].busy);
    end
    $display("test_prelu_layer done: rd=%0d acc=%0d done=%0d bubbles=%0d", n_rd, n_acc, n_done, n_bub);
  endtask

  task automatic test_plain_relu();
    bit to, rf;
    int n_rd, n_acc;
    n_rd = 0; n_acc = 0;
    cfg_prelu_en_i = 1'b0; cfg_grp_num_m1_i = 2; cfg_oh_num_m1_i = 0; cfg_param_base_i = 8'h40;
    run_layer(0, 0, 50, -1, 1'b0, 1'b0, to, rf);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL relu_timeout: got no done, expected done"); end
    foreach (trace[i]) begin
      if (trace[i].rd) n_rd++;
      if (trace[i].acc) begin
        checks++;
        if ({i[7:0], trace[i].grp, trace[i].slope} !== {8'(n_acc), GW'(n_acc), 32'h0}) begin
          errors++;
          $display("FAIL relu_beat%0d: got cycle=%0d grp=%0d slope=%08h expected cycle=%0d grp=%0d slope=0",
                   n_acc, i, trace[i].grp, trace[i].slope, n_acc, n_acc);
        end
        n_acc++;
      end
    end
    checks++;
    if (n_rd !== 0) begin errors++; $display("FAIL relu_no_read: got %0d reads expected 0", n_rd); end
    checks++;
    if (n_acc !== 3) begin errors++; $display("FAIL relu_accepts: got %0d expected 3", n_acc); end
    checks++;
    if (trace.size() !== 4 || trace[trace.size()-1].done !== 1'b1) begin
      errors++;
      $display("FAIL relu_done_at: got %0d cycles expected done at cycle 3", trace.size());
    end
    $display("test_plain_relu done: acc=%0d", n_acc);
  endtask

  task automatic test_handshake();
    bit to, rf, prev_rd;
    int eg, er, n_acc, n_done;
    logic [4*W-1:0] exp_slope;
    eg = 0; er = 0; n_acc = 0; n_done = 0; prev_rd = 1'b0;
    mem[8'h20] = 32'hA1B2C3D4;
    mem[8'h21] = 32'h11223344;
    cfg_prelu_en_i = 1'b1; cfg_grp_num_m1_i = 1; cfg_oh_num_m1_i = 3; cfg_param_base_i = 8'h20;
    run_layer(1, 1, 300, -1, 1'b0, 1'b0, to, rf);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL hs_timeout: got no done, expected done"); end
    foreach (trace[i]) begin
      if (trace[i].busy) begin
        if (trace[i].rd || prev_rd) begin
          checks++;
          if ({trace[i].crdy, trace[i].pvld} !== 2'b00) begin
            errors++;
            $display("FAIL hs_bubble_gate cyc%0d: got rdy,vld=%0b%0b expected 00", i, trace[i].crdy, trace[i].pvld);
          end
        end else begin
          checks++;
          if ({trace[i].crdy, trace[i].pvld} !== {trace[i].rdy, trace[i].vld}) begin
            errors++;
            $display("FAIL hs_passthru cyc%0d: got rdy,vld=%0b%0b expected %0b%0b",
                     i, trace[i].crdy, trace[i].pvld, trace[i].rdy, trace[i].vld);
          end
          exp_slope = (eg == 0) ? 32'hA1B2C3D4 : 32'h11223344;
          checks++;
          if (trace[i].slope !== exp_slope) begin
            errors++;
            $display("FAIL hs_slope cyc%0d: got %08h expected %08h", i, trace[i].slope, exp_slope);
          end
        end
        checks++;
        if ({trace[i].grp, trace[i].row} !== {GW'(eg), OW'(er)}) begin
          errors++;
          $display("FAIL hs_index cyc%0d: got grp=%0d row=%0d expected grp=%0d row=%0d",
                   i, trace[i].grp, trace[i].row, eg, er);
        end
      end
      prev_rd = trace[i].rd;
      if (trace[i].done) n_done++;
      if (trace[i].acc) begin
        n_acc++;
        if (er == 3) begin
          if (eg < 1) begin eg++; er = 0; end
        end else begin
          er++;
        end
      end
    end
    checks++;
    if (n_acc !== 8) begin errors++; $display("FAIL hs_accepts: got %0d expected 8", n_acc); end
    checks++;
    if (n_done !== 1) begin errors++; $display("FAIL hs_done_count: got %0d expected 1", n_done); end
    $display("test_handshake done: cycles=%0d acc=%0d", trace.size(), n_acc);
  endtask

  task automatic test_start_ignored();
    bit to, rf;
    int n_rd, n_acc;
    n_rd = 0; n_acc = 0;
    mem[8'h30] = 32'hDEADBEEF;
    cfg_prelu_en_i = 1'b1; cfg_grp_num_m1_i = 0; cfg_oh_num_m1_i = 1; cfg_param_base_i = 8'h30;
    run_layer(0, 0, 50, 3, 1'b0, 1'b0, to, rf);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL busy_start_timeout: got no done, expected done"); end
    foreach (trace[i]) begin
      if (trace[i].rd) begin
        checks++;
        if (trace[i].addr !== 8'h30) begin
          errors++;
          $display("FAIL busy_start_addr: got %02h expected 30", trace[i].addr);
        end
        n_rd++;
      end
      if (trace[i].acc) begin
        checks++;
        if (trace[i].slope !== 32'hDEADBEEF) begin
          errors++;
          $display("FAIL busy_start_slope: got %08h expected deadbeef", trace[i].slope);
        end
        n_acc++;
      end
    end
    checks++;
    if ({n_rd, n_acc, trace.size()} !== {32'd1, 32'd2, 32'd5}) begin
      errors++;
      $display("FAIL busy_start_counts: got rd=%0d acc=%0d cycles=%0d expected rd=1 acc=2 cycles=5",
               n_rd, n_acc, trace.size());
    end
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL busy_start_after: got busy=%0b expected 0", busy_o); end
    tick();
    $display("test_start_ignored done: acc=%0d", n_acc);
  endtask

  task automatic test_reset_mid();
    bit to, rf;
    int n_done, n_acc;
    n_done = 0; n_acc = 0;
    cfg_prelu_en_i = 1'b1; cfg_grp_num_m1_i = 1; cfg_oh_num_m1_i = 2; cfg_param_base_i = 8'h10;
    run_layer(0, 0, 50, -1, 1'b1, 1'b0, to, rf);
    checks++;
    if (rf !== 1'b1) begin errors++; $display("FAIL rst_mid_fired: got %0b expected 1", rf); end
    conv_vld_i = 1'b1;
    pipe_rdy_i = 1'b1;
    #1;
    checks++;
    if ({busy_o, done_o, prm_rd_en_o, pipe_vld_o, conv_rdy_o} !== 5'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl: got %05b expected 00000", {busy_o, done_o, prm_rd_en_o, pipe_vld_o, conv_rdy_o});
    end
    checks++;
    if ({prm_rd_addr_o, oc0, oc1, oc2, oc3, grp_idx_o, row_idx_o} !== '0) begin
      errors++;
      $display("FAIL rst_mid_data: got addr=%0h slopes=%0h grp=%0d row=%0d expected all 0",
               prm_rd_addr_o, {oc0, oc1, oc2, oc3}, grp_idx_o, row_idx_o);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      if (done_o) n_done++;
    end
    checks++;
    if (n_done !== 0) begin errors++; $display("FAIL rst_mid_no_done: got %0d done pulses expected 0", n_done); end
    cfg_prelu_en_i = 1'b0; cfg_grp_num_m1_i = 0; cfg_oh_num_m1_i = 1; cfg_param_base_i = 8'h00;
    run_layer(0, 0, 50, -1, 1'b0, 1'b0, to, rf);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL rst_restart_timeout: got no done, expected done"); end
    foreach (trace[i]) begin
      if (trace[i].acc) begin
        checks++;
        if ({trace[i].grp, trace[i].row} !== {GW'(0), OW'(n_acc)}) begin
          errors++;
          $display("FAIL rst_restart_beat%0d: got grp=%0d row=%0d expected grp=0 row=%0d",
                   n_acc, trace[i].grp, trace[i].row, n_acc);
        end
        n_acc++;
      end
    end
    checks++;
    if (n_acc !== 2) begin errors++; $display("FAIL rst_restart_accepts: got %0d expected 2", n_acc); end
    $display("test_reset_mid done: restart acc=%0d", n_acc);
  endtask

  task automatic test_degenerate();
    bit to, rf;
    int n_acc, n_busy;
    n_acc = 0; n_busy = 0;
    mem[8'hFF] = 32'h0A0B0C0D;
    cfg_prelu_en_i = 1'b1; cfg_grp_num_m1_i = 0; cfg_oh_num_m1_i = 0; cfg_param_base_i = 8'hFF;
    run_layer(0, 0, 50, -1, 1'b0, 1'b1, to, rf);
    checks++;
    if (to !== 1'b0) begin errors++; $display("FAIL degen_timeout: got no done, expected done"); end
    checks++;
    if ({trace[0].rd, trace[0].addr} !== {1'b1, 8'hFF}) begin
      errors++;
      $display("FAIL degen_rd: got rd=%0b addr=%02h expected rd=1 addr=ff", trace[0].rd, trace[0].addr);
    end
    foreach (trace[i]) begin
      if (trace[i].acc) begin
        checks++;
        if (trace[i].slope !== 32'h0A0B0C0D) begin
          errors++;
          $display("FAIL degen_slope: got %08h expected 0a0b0c0d", trace[i].slope);
        end
        n_acc++;
      end
    end
    checks++;
    if ({n_acc, trace.size()} !== {32'd1, 32'd4}) begin
      errors++;
      $display("FAIL degen_counts: got acc=%0d cycles=%0d expected acc=1 cycles=4", n_acc, trace.size());
    end
    for (int k = 0; k < 3; k++) begin
      if (busy_o || prm_rd_en_o) n_busy++;
      tick();
    end
    checks++;
    if (n_busy !== 0) begin
      errors++;
      $display("FAIL degen_start_in_done: got %0d busy cycles expected 0", n_busy);
    end
    $display("test_degenerate done: acc=%0d", n_acc);
  endtask

  initial begin
    rst = 1'b0;
    start_i = 1'b0;
    cfg_prelu_en_i = 1'b0;
    cfg_grp_num_m1_i = '0;
    cfg_oh_num_m1_i = '0;
    cfg_param_base_i = '0;
    conv_vld_i = 1'b0;
    pipe_rdy_i = 1'b0;
    for (int k = 0; k < 256; k++) mem[k] = '0;
    #2;
    test_reset();
    test_prelu_layer();
    test_plain_relu();
    test_handshake();
    test_start_ignored();
    test_reset_mid();
    test_degenerate();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pu_relu_ctrl.md
Name: pu_relu_ctrl

Overview:
- Sequencer for the 4-OC PReLU multiply pipe stage in the PU.
- Per layer, walks output-channel groups (4 OCs each) and rows (1 row per beat).
- Fetches each group's four PReLU slopes from the parameter buffer and holds them stable on the pipe's parameter inputs.
- Gates the conv→pipe valid/ready handshake so that parameters change only between groups.

Parameters:
- RELU_PARAM_WD, 8, width of one PReLU slope.
- OC_GRP_WD, 6, width of the OC-group counter (up to 64 groups of 4 OC).
- OH_WD, 10, width of the row counter.
- PARAM_AW, 8, parameter-buffer address width.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- start_i  in  1  layer start pulse; sampled only in IDLE
- cfg_prelu_en_i  in  1  1: fetch slopes; 0: plain ReLU, slopes forced to 0
- cfg_grp_num_m1_i  in  OC_GRP_WD  number of OC groups minus 1
- cfg_oh_num_m1_i  in  OH_WD  rows per group minus 1
- cfg_param_base_i  in  PARAM_AW  buffer address of group 0
- busy_o  out  1  high from accepted start until done
- done_o  out  1  one-cycle pulse after the last row of the last group is accepted
- prm_rd_en_o  out  1  parameter-buffer read strobe
- prm_rd_addr_o  out  PARAM_AW  read address
- prm_rd_data_i  in  4*RELU_PARAM_WD  read data, valid 1 cycle after rd_en; oc0 in the MSBs
- conv_vld_i  in  1  upstream row valid
- conv_rdy_o  out  1  upstream ready
- pipe_vld_o  out  1  valid to the PReLU pipe
- pipe_rdy_i  in  1  ready from the PReLU pipe
- relu_para_oc0_o..relu_para_oc3_o  out  RELU_PARAM_WD each  slopes for the current group
- grp_idx_o  out  OC_GRP_WD  current group index
- row_idx_o  out  OH_WD  current row index within the group

Behaviour:
- Reset (rst high at posedge):
  - State goes to IDLE; counters clear.
  - All outputs go to 0: busy, done, rd_en, addr, vld, rdy, slopes, idx.
  - A reset mid-operation abandons the layer; no done is issued.
- States: IDLE, FETCH, WAIT, RUN, DONE.
- IDLE:
  - start_i=1 latches cfg_*; grp=0, row=0, busy=1.
  - Next state is FETCH if prelu_en=1, else RUN with slopes=0.
  - All cfg_* are ignored outside IDLE.
- FETCH:
  - rd_en=1 for exactly one cycle, addr=base+grp (modulo 2^PARAM_AW).
  - Next state is WAIT.
- WAIT:
  - Slope registers capture prm_rd_data_i: oc0=[4W-1:3W], oc1=[3W-1:2W], oc2=[2W-1:W], oc3=[W-1:0].
  - Next state is RUN.
- RUN:
  - pipe_vld_o = conv_vld_i; conv_rdy_o = pipe_rdy_i (combinational pass-through).
  - In all other states both are 0.
  - On each accept (conv_vld_i & pipe_rdy_i), row increments.
  - Accept with row==oh_m1 and grp<grp_m1: row=0, grp+1, next state FETCH (or RUN again if prelu_en=0, with zero bubble).
  - Accept with row==oh_m1 and grp==grp_m1: next state DONE.
- DONE:
  - done_o=1 for one cycle; busy drops the same cycle.
  - Next state is IDLE; slopes hold their last value.
- Slope stability: slopes change only in WAIT, never in RUN. This is safe because the pipe registers its output on accept.
- Overhead per group: FETCH+WAIT costs 2 bubble cycles when prelu_en=1, 0 bubble cycles when prelu_en=0.
- Degenerate configuration: grp_m1=0 and oh_m1=0 gives a single beat, then DONE.
- start_i coincident with DONE is ignored; start is accepted only in IDLE.
- Counters never wrap: a terminal compare precedes any increment.

Decomposition:
- Shared package pu_pkg holds:
  - state encoding localparams: IDLE/FETCH/WAIT/RUN/DONE;
  - the PARAM_WORD_WD = 4*RELU_PARAM_WD constant;
  - the slope packing order (oc0 in the MSBs).
- No sub-module: a single FSM plus counters and slope registers.

Test Plan:
- prelu_en=1, grp_m1=1, oh_m1=2, base=0x10, buffer[0x10]=0x01020304, buffer[0x11]=0x05060708, rdy always 1:
  - rd at 0x10, then slopes 1/2/3/4 for 3 beats;
  - rd at 0x11, then slopes 5/6/7/8 for 3 beats;
  - done exactly once; 6 accepts; 4 bubble cycles.
- prelu_en=0, grp_m1=2, oh_m1=0:
  - no prm_rd_en ever; slopes=0;
  - 3 accepts back-to-back, then done.
- pipe_rdy_i toggling 1010, conv_vld_i random:
  - row_idx advances only on vld&rdy;
  - slopes constant within a group;
  - conv_rdy_o=0 during FETCH/WAIT.
- start_i pulsed while busy with different cfg:
  - ignored; original layer completes with original counts.
- rst asserted in RUN at row 1 of group 1:
  - next cycle all outputs 0, state IDLE, no done;
  - a new start then runs cleanly from grp 0.
- grp_m1=0, oh_m1=0, base=0xFF:
  - rd addr 0xFF, one accept, done;
  - start in the DONE cycle is ignored.
